// File: rtl/mpc_pkg.sv
// Shared constants and helpers for the multi_prescale_counter bank.
package mpc_pkg;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    localparam int DEF_WIDTH      = 64;
    localparam int DEF_CHANNELS   = 2;
    localparam int DEF_PRESCALE_W = 8;
    localparam int DEF_RESET_DIV  = 0;

    // A single-channel bank still needs a one-bit select port.
    function automatic int sel_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/mpc_channel.sv
// One counter channel: programmable prescaler, wrap/saturate counter,
// sticky overflow flag and a terminal-event tick pulse.
module mpc_channel
    import mpc_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int PRESCALE_W = DEF_PRESCALE_W,
    parameter int RESET_DIV  = DEF_RESET_DIV
)(
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  hit,
    input  logic                  en,
    input  logic                  clr,
    input  logic                  cfg_we,
    input  logic [PRESCALE_W-1:0] div_in,
    input  logic                  sat,
    output logic [WIDTH-1:0]      cnt,
    output logic                  ovf,
    output logic                  tick
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic [PRESCALE_W-1:0] pre;
    logic [PRESCALE_W-1:0] div;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt  <= '0;
            pre  <= '0;
            div  <= PRESCALE_W'(RESET_DIV);
            ovf  <= 1'b0;
            tick <= 1'b0;
        end else begin
            tick <= 1'b0;
            // Clear beats configuration, which beats counting.
            if (hit && clr) begin
                cnt <= '0;
                pre <= '0;
                ovf <= 1'b0;
            end else if (hit && cfg_we) begin
                div <= div_in;
                pre <= '0;
            end else if (hit && en) begin
                if (pre == div) begin
                    pre  <= '0;
                    tick <= 1'b1;
                    if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        ovf <= 1'b1;
                        if (sat != MODE_SAT) cnt <= '0;
                    end
                end else begin
                    pre <= pre + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/multi_prescale_counter.sv
// Bank of independent prescaled event counters addressed one channel per cycle.
// Optional MPC_SNAPSHOT_EN adds a Snap input and a Snapshot capture register.
module multi_prescale_counter
    import mpc_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int CHANNELS   = DEF_CHANNELS,
    parameter int PRESCALE_W = DEF_PRESCALE_W,
    parameter int RESET_DIV  = DEF_RESET_DIV,
    localparam int SEL_W     = sel_width(CHANNELS)
)(
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      En,
    input  logic [SEL_W-1:0]          Sel,
    input  logic                      Clr,
    input  logic                      CfgWe,
    input  logic [PRESCALE_W-1:0]     Div,
    input  logic                      Sat,
`ifdef MPC_SNAPSHOT_EN
    input  logic                      Snap,
    output logic [CHANNELS*WIDTH-1:0] Snapshot,
`endif
    output logic [CHANNELS*WIDTH-1:0] Count,
    output logic [CHANNELS-1:0]       Ovf,
    output logic [CHANNELS-1:0]       Tick
);

    logic [WIDTH-1:0] cnt_w [CHANNELS];

    // Out-of-range selects match no channel, so every command is ignored.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic hit;
        assign hit = (Sel == SEL_W'(c));

        mpc_channel #(
            .WIDTH      (WIDTH),
            .PRESCALE_W (PRESCALE_W),
            .RESET_DIV  (RESET_DIV)
        ) u_channel (
            .Clk    (Clk),
            .Reset  (Reset),
            .hit    (hit),
            .en     (En),
            .clr    (Clr),
            .cfg_we (CfgWe),
            .div_in (Div),
            .sat    (Sat),
            .cnt    (cnt_w[c]),
            .ovf    (Ovf[c]),
            .tick   (Tick[c])
        );

        assign Count[c*WIDTH +: WIDTH] = cnt_w[c];
    end

`ifdef MPC_SNAPSHOT_EN
    // Captures the counts as they stood before the edge that also applies any update.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Snapshot <= '0;
        end else if (Snap) begin
            Snapshot <= Count;
        end
    end
`endif

endmodule

// File: tb/tb_multi_prescale_counter.sv
// Self-checking bench for multi_prescale_counter: directed test-plan steps
// followed by randomized traffic, all checked against a behavioural model.
module tb_multi_prescale_counter;

    localparam int W    = 4;
    localparam int CH   = 3;
    localparam int PW   = 8;
    localparam int RD   = 0;
    localparam int SW   = 2;
    localparam int MAXV = (1 << W) - 1;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          En = 1'b0;
    logic [SW-1:0] Sel = '0;
    logic          Clr = 1'b0;
    logic          CfgWe = 1'b0;
    logic [PW-1:0] Div = '0;
    logic          Sat = 1'b0;
    logic [CH*W-1:0] Count;
    logic [CH-1:0]   Ovf;
    logic [CH-1:0]   Tick;
`ifdef MPC_SNAPSHOT_EN
    logic            Snap = 1'b0;
    logic [CH*W-1:0] Snapshot;
`endif

    int checks = 0;
    int failures = 0;

    int m_cnt [CH];
    int m_pre [CH];
    int m_div [CH];
    int m_snap[CH];
    bit m_ovf [CH];
    bit m_tick[CH];
    bit sat_mode = 1'b0;
    bit snap_req = 1'b0;

    always #5 Clk = ~Clk;

    multi_prescale_counter #(
        .WIDTH      (W),
        .CHANNELS   (CH),
        .PRESCALE_W (PW),
        .RESET_DIV  (RD)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .En       (En),
        .Sel      (Sel),
        .Clr      (Clr),
        .CfgWe    (CfgWe),
        .Div      (Div),
        .Sat      (Sat),
`ifdef MPC_SNAPSHOT_EN
        .Snap     (Snap),
        .Snapshot (Snapshot),
`endif
        .Count    (Count),
        .Ovf      (Ovf),
        .Tick     (Tick)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: a channel is a count of terminal events taken modulo
    // (or clamped at) 2^W, where a terminal event is every (div+1)-th event.
    task automatic model_step(input bit rst, input bit en, input bit clr, input bit cfg,
                              input int sel, input int dv, input bit sat, input bit snap);
        for (int c = 0; c < CH; c++) m_tick[c] = 1'b0;
        for (int c = 0; c < CH; c++) begin
            if (rst) m_snap[c] = 0;
            else if (snap) m_snap[c] = m_cnt[c];
        end
        if (rst) begin
            for (int c = 0; c < CH; c++) begin
                m_cnt[c] = 0; m_pre[c] = 0; m_div[c] = RD; m_ovf[c] = 1'b0;
            end
        end else if (sel < CH) begin
            if (clr) begin
                m_cnt[sel] = 0; m_pre[sel] = 0; m_ovf[sel] = 1'b0;
            end else if (cfg) begin
                m_div[sel] = dv; m_pre[sel] = 0;
            end else if (en) begin
                m_pre[sel] = (m_pre[sel] + 1) % (m_div[sel] + 1);
                if (m_pre[sel] == 0) begin
                    m_tick[sel] = 1'b1;
                    if (m_cnt[sel] == MAXV) m_ovf[sel] = 1'b1;
                    m_cnt[sel] = sat ? ((m_cnt[sel] + 1 > MAXV) ? MAXV : m_cnt[sel] + 1)
                                     : (m_cnt[sel] + 1) % (MAXV + 1);
                end
            end
        end
    endtask

    task automatic check_all();
        logic [CH*W-1:0] e_cnt;
        logic [CH*W-1:0] e_snap;
        logic [CH-1:0]   e_ovf;
        logic [CH-1:0]   e_tick;
        for (int c = 0; c < CH; c++) begin
            e_cnt[c*W +: W]  = W'(m_cnt[c]);
            e_snap[c*W +: W] = W'(m_snap[c]);
            e_ovf[c]         = m_ovf[c];
            e_tick[c]        = m_tick[c];
        end
        check("model_count", 64'(Count), 64'(e_cnt));
        check("model_ovf", 64'(Ovf), 64'(e_ovf));
        check("model_tick", 64'(Tick), 64'(e_tick));
`ifdef MPC_SNAPSHOT_EN
        check("model_snapshot", 64'(Snapshot), 64'(e_snap));
`else
        if (e_snap != e_snap) check("model_snapshot", 64'(e_snap), 64'(e_cnt));
`endif
    endtask

    task automatic step(input bit rst, input bit en, input bit clr, input bit cfg,
                        input int sel, input int dv, input bit sat);
        Reset = rst; En = en; Clr = clr; CfgWe = cfg;
        Sel = sel[SW-1:0]; Div = dv[PW-1:0]; Sat = sat;
`ifdef MPC_SNAPSHOT_EN
        Snap = snap_req;
`endif
        @(posedge Clk);
        model_step(rst, en, clr, cfg, sel, dv, sat, snap_req);
        #1;
        check_all();
    endtask

    task automatic ev(input int sel);
        step(1'b0, 1'b1, 1'b0, 1'b0, sel, 0, sat_mode);
    endtask

    task automatic cfg(input int sel, input int dv);
        step(1'b0, 1'b0, 1'b0, 1'b1, sel, dv, sat_mode);
    endtask

    task automatic clr(input int sel);
        step(1'b0, 1'b0, 1'b1, 1'b0, sel, 0, sat_mode);
    endtask

    logic [CH*W-1:0] saved;

    initial begin
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        check("rst_count", 64'(Count), 64'd0);
        check("rst_ovf", 64'(Ovf), 64'd0);
        check("rst_tick", 64'(Tick), 64'd0);

        // Divide-by-1 counting on channel 0.
        for (int i = 0; i < 10; i++) begin
            ev(0);
            check("div1_tick0", 64'(Tick[0]), 64'd1);
        end
        check("div1_count0", 64'(Count[0 +: W]), 64'd10);
        check("div1_count1", 64'(Count[W +: W]), 64'd0);

        // Divide-by-4 on channel 1.
        cfg(1, 3);
        for (int i = 1; i <= 12; i++) begin
            ev(1);
            check("div4_tick1", 64'(Tick[1]), 64'((i % 4) == 0));
        end
        check("div4_count1", 64'(Count[W +: W]), 64'd3);

        // Wrap then saturate on channel 2.
        sat_mode = 1'b0;
        clr(2);
        for (int i = 0; i < 17; i++) ev(2);
        check("wrap_count2", 64'(Count[2*W +: W]), 64'd1);
        check("wrap_ovf2", 64'(Ovf[2]), 64'd1);
        clr(2);
        check("clr_ovf2", 64'(Ovf[2]), 64'd0);
        sat_mode = 1'b1;
        for (int i = 0; i < 17; i++) ev(2);
        check("sat_count2", 64'(Count[2*W +: W]), 64'd15);
        check("sat_ovf2", 64'(Ovf[2]), 64'd1);
        sat_mode = 1'b0;

        // Clr wins over En; CfgWe drops En and restarts the prescaler.
        clr(0);
        for (int i = 0; i < 5; i++) ev(0);
        check("pre_clr_count0", 64'(Count[0 +: W]), 64'd5);
        step(1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
        check("clr_en_count0", 64'(Count[0 +: W]), 64'd0);
        check("clr_en_ovf0", 64'(Ovf[0]), 64'd0);
        check("clr_en_tick0", 64'(Tick[0]), 64'd0);
        ev(1); ev(1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1, 3, 1'b0);
        check("cfg_en_tick1", 64'(Tick[1]), 64'd0);
        check("cfg_en_count1", 64'(Count[W +: W]), 64'd3);
        for (int i = 0; i < 3; i++) ev(1);
        check("cfg_pre_cleared", 64'(Count[W +: W]), 64'd3);
        ev(1);
        check("cfg_pre_step", 64'(Count[W +: W]), 64'd4);
        check("cfg_pre_tick", 64'(Tick[1]), 64'd1);

        // Reset discards partial prescaler progress.
        cfg(0, 3);
        ev(0); ev(0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        check("mid_rst_count1", 64'(Count[W +: W]), 64'd0);
        cfg(0, 3);
        for (int i = 0; i < 4; i++) ev(0);
        check("post_rst_count0", 64'(Count[0 +: W]), 64'd1);

        // Out-of-range select leaves every channel untouched.
        saved = Count;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'(i % 2), 1'(i == 2), 1'(i == 4), 3, 0, 1'b0);
            check("oob_tick", 64'(Tick), 64'd0);
        end
        check("oob_count", 64'(Count), 64'(saved));

`ifdef MPC_SNAPSHOT_EN
        clr(0);
        cfg(0, 0);
        for (int i = 0; i < 7; i++) ev(0);
        snap_req = 1'b1;
        ev(0);
        snap_req = 1'b0;
        check("snap_value0", 64'(Snapshot[0 +: W]), 64'd7);
        check("snap_count0", 64'(Count[0 +: W]), 64'd8);
`endif

        // Randomized traffic including rare resets and out-of-range selects.
        for (int i = 0; i < 400; i++) begin
            snap_req = ($urandom_range(0, 9) == 0);
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 11) == 0,
                 int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)));
        end
        snap_req = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
